trap_csr_unit: RTL and testbench
================================

TRAP_CSR_UNIT -- requirements
Module: trap_csr_unit

Interface
REQ-001 SHALL have parameter MTVEC_RESET, default 32'h0000_0000, reset value of mtvec.
REQ-002 SHALL have parameter HART_ID, default 0, value returned by mhartid.
REQ-003 SHALL have ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- en_exception_i  in  1  exception request from pipeline controller.
- exception_program_counter_i  in  32  faulting PC.
- exception_cause_i  in  3  0 instr-misaligned, 1 illegal, 2 breakpoint, 3 load-misaligned, 4 store-misaligned, 5 ecall-M.
- exception_tval_i  in  32  faulting address/instruction.
- interrupt_machine_software_i / _timer_i / _external_i  in  1 each  level interrupt lines.
- interrupt_program_counter_i  in  32  resume PC for interrupts.
- mret_i  in  1  MRET retiring.
- instret_i  in  1  instruction retired this cycle.
- csr_en_i  in  1  CSR access valid.
- csr_op_i  in  2  01 RW, 10 RS, 11 RC; 00 is read-only access.
- csr_addr_i  in  12  CSR address.
- csr_wdata_i  in  32  write operand.
- csr_rdata_o  out  32  old CSR value, combinational.
- csr_illegal_o  out  1  access illegal, combinational.
- redirect_o  out  1  one-cycle fetch redirect / pipeline flush.
- redirect_pc_o  out  32  redirect target.

Function
REQ-004 SHALL implement mstatus (MIE[3], MPIE[7], MPP[12:11] fixed 2'b11), mie (MSIE[3], MTIE[7], MEIE[11]), mip (read-only, mirrors interrupt lines), mtvec, mepc, mcause, mtval, mscratch, mcycle/mcycleh, minstret/minstreth, misa (read-only, RV32I), mhartid (read-only).
REQ-005 SHALL run a 2-state FSM: IDLE and REDIRECT; REDIRECT always returns to IDLE after exactly one cycle.
REQ-006 In IDLE, event priority SHALL be exception > interrupt > mret; the selected event moves FSM to REDIRECT at the next edge.
REQ-007 Interrupt pending SHALL require MIE=1 and (mip & mie) != 0; priority external (code 11) > software (3) > timer (7).
REQ-008 On trap entry edge: mepc <= PC with bits[1:0] cleared, mcause <= {interrupt bit, code}, mtval <= tval (0 for interrupts), MPIE <= MIE, MIE <= 0.
REQ-009 Exception cause 0..5 SHALL map to mcause code 0, 2, 3, 4, 6, 11; cause 6/7 SHALL map to code 2.
REQ-010 On mret edge: MIE <= MPIE, MPIE <= 1.
REQ-011 redirect_o SHALL be registered, high only in REDIRECT; redirect_pc_o = mtvec base for exceptions, base + 4*code for interrupts when mtvec.MODE=1, mepc for mret.
REQ-012 In REDIRECT, all exception, interrupt and mret inputs SHALL be ignored.
REQ-013 mtvec write SHALL force MODE to 0 when written MODE >= 2; mepc writes SHALL clear bits[1:0].
REQ-014 CSR write SHALL occur at the edge when csr_en_i=1, csr_op_i != 00 and access legal; RS/RC with csr_wdata_i=0 SHALL not write.
REQ-015 csr_illegal_o SHALL be 1 for unimplemented addresses or a writing op to a read-only CSR; illegal access SHALL not modify state.
REQ-016 A trap or mret in the same cycle as a CSR write SHALL win; the CSR write SHALL be dropped.
REQ-017 mcycle SHALL increment every cycle; minstret SHALL increment when instret_i=1; a same-cycle CSR write of either half SHALL win over increment; 64-bit wrap to 0.

Reset
REQ-018 rst_i=1 SHALL set FSM to IDLE, redirect_o=0, redirect_pc_o=0, mstatus=32'h0000_1800, mtvec=MTVEC_RESET, all other writable CSRs and counters 0.
REQ-019 Reset asserted in REDIRECT SHALL drop redirect_o in the following cycle, with no CSR update.

Structure
REQ-020 Exception cause encodings, mcause codes, CSR addresses and csr_op encodings SHALL live in shared package trap_csr_pkg, also used by pipeline_controller.
REQ-021 mcycle/minstret SHALL use one sub-module csr_counter64 (increment enable, per-half write).

Verification
REQ-022 mtvec=0x100, exception cause 3, PC 0x200, tval 0x203 -> next cycle redirect_o=1, pc 0x100; mcause=4, mepc=0x200, mtval=0x203, MIE=0.
REQ-023 mtvec=0x101, MIE=1, MTIE=1, timer=1 -> redirect pc 0x11C, mcause=0x8000_0007.
REQ-024 MIE=1, all interrupts enabled and pending simultaneously -> mcause=0x8000_000B.
REQ-025 Exception, CSR RW to mscratch same cycle -> trap taken, mscratch unchanged.
REQ-026 mret with mepc=0x300, MPIE=1 -> redirect pc 0x300, MIE=1, MPIE=1.
REQ-027 RW write to mhartid -> csr_illegal_o=1, mhartid stays HART_ID; mcycle=0xFFFF_FFFF_FFFF_FFFF -> 0 next cycle.

Source files
------------

// File: rtl/trap_csr_pkg.sv
// Shared trap/CSR definitions: cause encodings, mcause codes, CSR addresses
// and CSR operation encodings used by the trap unit and the pipeline controller.
package trap_csr_pkg;

    typedef enum logic [1:0] {
        CSR_OP_READ = 2'b00,
        CSR_OP_RW   = 2'b01,
        CSR_OP_RS   = 2'b10,
        CSR_OP_RC   = 2'b11
    } csr_op_e;

    typedef enum logic [2:0] {
        EXC_INSTR_MISALIGNED = 3'd0,
        EXC_ILLEGAL_INSTR    = 3'd1,
        EXC_BREAKPOINT       = 3'd2,
        EXC_LOAD_MISALIGNED  = 3'd3,
        EXC_STORE_MISALIGNED = 3'd4,
        EXC_ECALL_M          = 3'd5
    } exc_cause_e;

    typedef enum logic {
        ST_IDLE     = 1'b0,
        ST_REDIRECT = 1'b1
    } trap_state_e;

    localparam logic [3:0] MCODE_INSTR_MISALIGNED = 4'd0;
    localparam logic [3:0] MCODE_ILLEGAL_INSTR    = 4'd2;
    localparam logic [3:0] MCODE_BREAKPOINT       = 4'd3;
    localparam logic [3:0] MCODE_LOAD_MISALIGNED  = 4'd4;
    localparam logic [3:0] MCODE_STORE_MISALIGNED = 4'd6;
    localparam logic [3:0] MCODE_ECALL_M          = 4'd11;
    localparam logic [3:0] MCODE_SW_IRQ           = 4'd3;
    localparam logic [3:0] MCODE_TIMER_IRQ        = 4'd7;
    localparam logic [3:0] MCODE_EXT_IRQ          = 4'd11;

    localparam logic [11:0] CSR_MSTATUS   = 12'h300;
    localparam logic [11:0] CSR_MISA      = 12'h301;
    localparam logic [11:0] CSR_MIE       = 12'h304;
    localparam logic [11:0] CSR_MTVEC     = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
    localparam logic [11:0] CSR_MEPC      = 12'h341;
    localparam logic [11:0] CSR_MCAUSE    = 12'h342;
    localparam logic [11:0] CSR_MTVAL     = 12'h343;
    localparam logic [11:0] CSR_MIP       = 12'h344;
    localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
    localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
    localparam logic [11:0] CSR_MHARTID   = 12'hF14;

    localparam logic [31:0] MISA_VALUE    = 32'h4000_0100;
    localparam logic [31:0] MIE_MASK      = 32'h0000_0888;

    // Maps the pipeline's 3-bit exception cause onto the architectural mcause code;
    // the two unused cause values fall back to the illegal-instruction code.
    function automatic logic [3:0] exc_code(input logic [2:0] cause);
        logic [3:0] code;
        case (cause)
            EXC_INSTR_MISALIGNED: code = MCODE_INSTR_MISALIGNED;
            EXC_ILLEGAL_INSTR:    code = MCODE_ILLEGAL_INSTR;
            EXC_BREAKPOINT:       code = MCODE_BREAKPOINT;
            EXC_LOAD_MISALIGNED:  code = MCODE_LOAD_MISALIGNED;
            EXC_STORE_MISALIGNED: code = MCODE_STORE_MISALIGNED;
            EXC_ECALL_M:          code = MCODE_ECALL_M;
            default:              code = MCODE_ILLEGAL_INSTR;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/csr_counter64.sv
// 64-bit performance counter with increment enable and independent writes of
// each 32-bit half; a write to either half suppresses that cycle's increment.
module csr_counter64 (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        inc_en_i,
    input  logic        wr_lo_i,
    input  logic        wr_hi_i,
    input  logic [31:0] wdata_i,
    output logic [63:0] value_o
);

    logic [63:0] count_q;

    // Count register: reset, then half writes, then the free-running increment.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else if (wr_lo_i || wr_hi_i) begin
            if (wr_lo_i) count_q[31:0]  <= wdata_i;
            if (wr_hi_i) count_q[63:32] <= wdata_i;
        end else if (inc_en_i) begin
            count_q <= count_q + 64'd1;
        end
    end

    assign value_o = count_q;

endmodule

// File: rtl/trap_csr_unit.sv
// Machine-mode trap and CSR unit: holds the M-mode CSRs, arbitrates
// exception/interrupt/mret events and issues a one-cycle fetch redirect.
module trap_csr_unit #(
    parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
    parameter int unsigned HART_ID     = 0
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        en_exception_i,
    input  logic [31:0] exception_program_counter_i,
    input  logic [2:0]  exception_cause_i,
    input  logic [31:0] exception_tval_i,
    input  logic        interrupt_machine_software_i,
    input  logic        interrupt_machine_timer_i,
    input  logic        interrupt_machine_external_i,
    input  logic [31:0] interrupt_program_counter_i,
    input  logic        mret_i,
    input  logic        instret_i,
    input  logic        csr_en_i,
    input  logic [1:0]  csr_op_i,
    input  logic [11:0] csr_addr_i,
    input  logic [31:0] csr_wdata_i,
    output logic [31:0] csr_rdata_o,
    output logic        csr_illegal_o,
    output logic        redirect_o,
    output logic [31:0] redirect_pc_o
);

    import trap_csr_pkg::*;

    trap_state_e state_q, state_d;

    logic        mstatus_mie_q, mstatus_mpie_q;
    logic [31:0] mie_q, mtvec_q, mepc_q, mcause_q, mtval_q, mscratch_q;
    logic [63:0] mcycle_w, minstret_w;
    logic [31:0] mstatus_w, mip_w, mtvec_base_w, irq_active_w;
    logic [3:0]  irq_code_w, trap_code_w;
    logic        irq_pending_w;

    logic [31:0] csr_rdata_w, csr_wval_w, target_pc_w;
    logic        csr_known_w, csr_ro_w, csr_write_op_w, csr_skip_w, csr_illegal_w, csr_we_w;
    logic        take_exc_w, take_irq_w, take_mret_w, take_any_w;
    logic        redirect_q;
    logic [31:0] redirect_pc_q;

    assign mstatus_w    = {19'd0, 2'b11, 3'd0, mstatus_mpie_q, 3'd0, mstatus_mie_q, 3'd0};
    assign mip_w        = 32'({interrupt_machine_external_i, 3'b000,
                               interrupt_machine_timer_i, 3'b000,
                               interrupt_machine_software_i, 3'b000});
    assign mtvec_base_w = mtvec_q & ~32'd3;

    assign irq_active_w  = mip_w & mie_q;
    assign irq_pending_w = mstatus_mie_q && (|irq_active_w);
    assign irq_code_w    = irq_active_w[11] ? MCODE_EXT_IRQ :
                           irq_active_w[3]  ? MCODE_SW_IRQ  : MCODE_TIMER_IRQ;
    assign trap_code_w   = take_irq_w ? irq_code_w : exc_code(exception_cause_i);

    // CSR read mux: old value of the addressed CSR plus legality attributes.
    always_comb begin
        csr_rdata_w = '0;
        csr_known_w = 1'b1;
        csr_ro_w    = 1'b0;
        case (csr_addr_i)
            CSR_MSTATUS:   csr_rdata_w = mstatus_w;
            CSR_MISA:      begin csr_rdata_w = MISA_VALUE; csr_ro_w = 1'b1; end
            CSR_MIE:       csr_rdata_w = mie_q;
            CSR_MTVEC:     csr_rdata_w = mtvec_q;
            CSR_MSCRATCH:  csr_rdata_w = mscratch_q;
            CSR_MEPC:      csr_rdata_w = mepc_q;
            CSR_MCAUSE:    csr_rdata_w = mcause_q;
            CSR_MTVAL:     csr_rdata_w = mtval_q;
            CSR_MIP:       begin csr_rdata_w = mip_w; csr_ro_w = 1'b1; end
            CSR_MCYCLE:    csr_rdata_w = mcycle_w[31:0];
            CSR_MCYCLEH:   csr_rdata_w = mcycle_w[63:32];
            CSR_MINSTRET:  csr_rdata_w = minstret_w[31:0];
            CSR_MINSTRETH: csr_rdata_w = minstret_w[63:32];
            CSR_MHARTID:   begin csr_rdata_w = 32'(HART_ID); csr_ro_w = 1'b1; end
            default:       csr_known_w = 1'b0;
        endcase
    end

    // Write operand after applying the read-modify-write operation.
    always_comb begin
        csr_wval_w = csr_rdata_w;
        case (csr_op_i)
            CSR_OP_RW: csr_wval_w = csr_wdata_i;
            CSR_OP_RS: csr_wval_w = csr_rdata_w | csr_wdata_i;
            CSR_OP_RC: csr_wval_w = csr_rdata_w & ~csr_wdata_i;
            default:   csr_wval_w = csr_rdata_w;
        endcase
    end

    assign csr_write_op_w = (csr_op_i != CSR_OP_READ);
    assign csr_skip_w     = (csr_op_i != CSR_OP_RW) && (csr_wdata_i == 32'd0);
    assign csr_illegal_w  = csr_en_i && (!csr_known_w || (csr_write_op_w && csr_ro_w));
    assign csr_we_w       = csr_en_i && csr_write_op_w && !csr_illegal_w && !csr_skip_w && !take_any_w;

    assign csr_rdata_o   = csr_rdata_w;
    assign csr_illegal_o = csr_illegal_w;

    // Event arbitration and next state: exception beats interrupt beats mret, only in IDLE.
    always_comb begin
        state_d     = state_q;
        take_exc_w  = 1'b0;
        take_irq_w  = 1'b0;
        take_mret_w = 1'b0;
        target_pc_w = '0;
        case (state_q)
            ST_IDLE: begin
                if (en_exception_i) begin
                    take_exc_w  = 1'b1;
                    target_pc_w = mtvec_base_w;
                end else if (irq_pending_w) begin
                    take_irq_w  = 1'b1;
                    target_pc_w = (mtvec_q[1:0] == 2'b01) ?
                                  mtvec_base_w + {26'd0, irq_code_w, 2'b00} : mtvec_base_w;
                end else if (mret_i) begin
                    take_mret_w = 1'b1;
                    target_pc_w = mepc_q;
                end
                if (take_exc_w || take_irq_w || take_mret_w) state_d = ST_REDIRECT;
            end
            ST_REDIRECT: state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    assign take_any_w = take_exc_w || take_irq_w || take_mret_w;

    // FSM state and registered redirect outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= ST_IDLE;
            redirect_q    <= 1'b0;
            redirect_pc_q <= '0;
        end else begin
            state_q    <= state_d;
            redirect_q <= (state_d == ST_REDIRECT);
            if (take_any_w) redirect_pc_q <= target_pc_w;
        end
    end

    assign redirect_o    = redirect_q;
    assign redirect_pc_o = redirect_pc_q;

    // Writable CSRs: trap entry and mret take precedence over software writes.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mstatus_mie_q  <= 1'b0;
            mstatus_mpie_q <= 1'b0;
            mie_q          <= '0;
            mtvec_q        <= MTVEC_RESET;
            mepc_q         <= '0;
            mcause_q       <= '0;
            mtval_q        <= '0;
            mscratch_q     <= '0;
        end else if (take_exc_w || take_irq_w) begin
            mepc_q         <= (take_irq_w ? interrupt_program_counter_i
                                          : exception_program_counter_i) & ~32'd3;
            mcause_q       <= {take_irq_w, 27'd0, trap_code_w};
            mtval_q        <= take_irq_w ? 32'd0 : exception_tval_i;
            mstatus_mpie_q <= mstatus_mie_q;
            mstatus_mie_q  <= 1'b0;
        end else if (take_mret_w) begin
            mstatus_mie_q  <= mstatus_mpie_q;
            mstatus_mpie_q <= 1'b1;
        end else if (csr_we_w) begin
            case (csr_addr_i)
                CSR_MSTATUS: begin
                    mstatus_mie_q  <= csr_wval_w[3];
                    mstatus_mpie_q <= csr_wval_w[7];
                end
                CSR_MIE:      mie_q      <= csr_wval_w & MIE_MASK;
                CSR_MTVEC:    mtvec_q    <= {csr_wval_w[31:2],
                                             (csr_wval_w[1:0] >= 2'd2) ? 2'b00 : csr_wval_w[1:0]};
                CSR_MSCRATCH: mscratch_q <= csr_wval_w;
                CSR_MEPC:     mepc_q     <= csr_wval_w & ~32'd3;
                CSR_MCAUSE:   mcause_q   <= csr_wval_w;
                CSR_MTVAL:    mtval_q    <= csr_wval_w;
                default:      ;
            endcase
        end
    end

    csr_counter64 u_mcycle (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .inc_en_i(1'b1),
        .wr_lo_i (csr_we_w && (csr_addr_i == CSR_MCYCLE)),
        .wr_hi_i (csr_we_w && (csr_addr_i == CSR_MCYCLEH)),
        .wdata_i (csr_wval_w),
        .value_o (mcycle_w)
    );

    csr_counter64 u_minstret (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .inc_en_i(instret_i),
        .wr_lo_i (csr_we_w && (csr_addr_i == CSR_MINSTRET)),
        .wr_hi_i (csr_we_w && (csr_addr_i == CSR_MINSTRETH)),
        .wdata_i (csr_wval_w),
        .value_o (minstret_w)
    );

endmodule

// File: tb/tb_trap_csr_unit.sv
// Scoreboard bench for trap_csr_unit: directed scenarios followed by random
// traffic, all checked against a behavioural model of the CSR/trap rules.
module tb_trap_csr_unit;

    localparam logic [31:0] TB_MTVEC_RESET = 32'h0000_0080;
    localparam int unsigned TB_HART_ID     = 5;

    logic        clk_i = 1'b0;
    logic        rst_i, en_exception_i, mret_i, instret_i, csr_en_i;
    logic        interrupt_machine_software_i, interrupt_machine_timer_i, interrupt_machine_external_i;
    logic [31:0] exception_program_counter_i, exception_tval_i, interrupt_program_counter_i;
    logic [2:0]  exception_cause_i;
    logic [1:0]  csr_op_i;
    logic [11:0] csr_addr_i;
    logic [31:0] csr_wdata_i, csr_rdata_o, redirect_pc_o;
    logic        csr_illegal_o, redirect_o;

    trap_csr_unit #(.MTVEC_RESET(TB_MTVEC_RESET), .HART_ID(TB_HART_ID)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .en_exception_i(en_exception_i),
        .exception_program_counter_i(exception_program_counter_i),
        .exception_cause_i(exception_cause_i),
        .exception_tval_i(exception_tval_i),
        .interrupt_machine_software_i(interrupt_machine_software_i),
        .interrupt_machine_timer_i(interrupt_machine_timer_i),
        .interrupt_machine_external_i(interrupt_machine_external_i),
        .interrupt_program_counter_i(interrupt_program_counter_i),
        .mret_i(mret_i), .instret_i(instret_i),
        .csr_en_i(csr_en_i), .csr_op_i(csr_op_i), .csr_addr_i(csr_addr_i),
        .csr_wdata_i(csr_wdata_i), .csr_rdata_o(csr_rdata_o),
        .csr_illegal_o(csr_illegal_o),
        .redirect_o(redirect_o), .redirect_pc_o(redirect_pc_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        bit          rst;
        bit          exc;
        logic [31:0] exc_pc;
        logic [2:0]  cause;
        logic [31:0] tval;
        bit          msip, mtip, meip;
        logic [31:0] irq_pc;
        bit          mret;
        bit          instret;
        bit          csr_en;
        logic [1:0]  op;
        logic [11:0] addr;
        logic [31:0] wdata;
    } stim_t;

    int checks = 0;
    int errors = 0;

    logic [32:0] exp_rd[$];
    logic [31:0] exp_pc[$];

    int exc_map[8] = '{0, 2, 3, 4, 6, 11, 2, 2};
    logic [11:0] addr_pool[17] = '{12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341,
                                   12'h342, 12'h343, 12'h344, 12'hB00, 12'hB02, 12'hB80,
                                   12'hB82, 12'hF14, 12'h7C0, 12'h345, 12'hB01};

    bit          m_mie, m_mpie, m_redirect;
    logic [31:0] m_ie, m_mtvec, m_mepc, m_mcause, m_mtval, m_mscratch;
    logic [63:0] m_mcycle, m_minstret;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic void resetModel();
        m_mie = 0; m_mpie = 0; m_redirect = 0;
        m_ie = 0; m_mtvec = TB_MTVEC_RESET; m_mepc = 0; m_mcause = 0;
        m_mtval = 0; m_mscratch = 0; m_mcycle = 0; m_minstret = 0;
    endfunction

    function automatic logic [31:0] modelRead(input logic [11:0] addr, input bit msip, input bit mtip,
                                              input bit meip, output bit known, output bit ro);
        logic [31:0] r;
        known = 1; ro = 0; r = 0;
        case (addr)
            12'h300: r = 32'h1800 | (32'(m_mie) << 3) | (32'(m_mpie) << 7);
            12'h301: begin r = 32'h4000_0100; ro = 1; end
            12'h304: r = m_ie;
            12'h305: r = m_mtvec;
            12'h340: r = m_mscratch;
            12'h341: r = m_mepc;
            12'h342: r = m_mcause;
            12'h343: r = m_mtval;
            12'h344: begin r = (32'(meip) << 11) | (32'(mtip) << 7) | (32'(msip) << 3); ro = 1; end
            12'hB00: r = m_mcycle[31:0];
            12'hB80: r = m_mcycle[63:32];
            12'hB02: r = m_minstret[31:0];
            12'hB82: r = m_minstret[63:32];
            12'hF14: begin r = TB_HART_ID; ro = 1; end
            default: known = 0;
        endcase
        return r;
    endfunction

    function automatic void trapEntry(input bit irq, input int code, input logic [31:0] pc,
                                      input logic [31:0] tval);
        m_mepc   = pc & ~32'd3;
        m_mcause = {irq, 31'(code)};
        m_mtval  = irq ? 32'd0 : tval;
        m_mpie   = m_mie;
        m_mie    = 0;
    endfunction

    function automatic void modelWrite(input logic [11:0] addr, input logic [31:0] v);
        case (addr)
            12'h300: begin m_mie = v[3]; m_mpie = v[7]; end
            12'h304: m_ie = v & 32'h888;
            12'h305: m_mtvec = {v[31:2], (v[1:0] >= 2'd2) ? 2'b00 : v[1:0]};
            12'h340: m_mscratch = v;
            12'h341: m_mepc = v & ~32'd3;
            12'h342: m_mcause = v;
            12'h343: m_mtval = v;
            12'hB00: m_mcycle[31:0] = v;
            12'hB80: m_mcycle[63:32] = v;
            12'hB02: m_minstret[31:0] = v;
            12'hB82: m_minstret[63:32] = v;
            default: ;
        endcase
    endfunction

    // Drives one cycle of stimulus, queues the expected responses and advances the model.
    task automatic applyStimulus(input stim_t s);
        logic [31:0] rd, nv, target;
        bit known, ro, illegal, ev, pending, cyc_wr, ins_wr;
        int code;
        rst_i = s.rst; en_exception_i = s.exc; exception_program_counter_i = s.exc_pc;
        exception_cause_i = s.cause; exception_tval_i = s.tval;
        interrupt_machine_software_i = s.msip; interrupt_machine_timer_i = s.mtip;
        interrupt_machine_external_i = s.meip; interrupt_program_counter_i = s.irq_pc;
        mret_i = s.mret; instret_i = s.instret; csr_en_i = s.csr_en; csr_op_i = s.op;
        csr_addr_i = s.addr; csr_wdata_i = s.wdata;

        rd = modelRead(s.addr, s.msip, s.mtip, s.meip, known, ro);
        illegal = !known || (s.op != 2'b00 && ro);
        if (s.csr_en) exp_rd.push_back({illegal, rd});

        ev = 0; cyc_wr = 0; ins_wr = 0; target = 0;
        if (s.rst) begin
            resetModel();
        end else begin
            if (!m_redirect) begin
                pending = m_mie && ((s.meip && m_ie[11]) || (s.msip && m_ie[3]) || (s.mtip && m_ie[7]));
                code = (s.meip && m_ie[11]) ? 11 : (s.msip && m_ie[3]) ? 3 : 7;
                if (s.exc) begin
                    target = m_mtvec & ~32'd3;
                    trapEntry(0, exc_map[s.cause], s.exc_pc, s.tval);
                    ev = 1;
                end else if (pending) begin
                    target = (m_mtvec & ~32'd3) + ((m_mtvec[1:0] == 2'd1) ? 32'(4 * code) : 32'd0);
                    trapEntry(1, code, s.irq_pc, 32'd0);
                    ev = 1;
                end else if (s.mret) begin
                    target = m_mepc;
                    m_mie = m_mpie;
                    m_mpie = 1;
                    ev = 1;
                end
                if (ev) exp_pc.push_back(target);
            end
            if (s.csr_en && s.op != 2'b00 && !illegal && !ev && !(s.op != 2'b01 && s.wdata == 0)) begin
                case (s.op)
                    2'b01:   nv = s.wdata;
                    2'b10:   nv = rd | s.wdata;
                    default: nv = rd & ~s.wdata;
                endcase
                modelWrite(s.addr, nv);
                cyc_wr = (s.addr == 12'hB00) || (s.addr == 12'hB80);
                ins_wr = (s.addr == 12'hB02) || (s.addr == 12'hB82);
            end
            if (!cyc_wr) m_mcycle = m_mcycle + 64'd1;
            if (!ins_wr && s.instret) m_minstret = m_minstret + 64'd1;
            m_redirect = ev;
        end
        @(posedge clk_i);
        #1;
    endtask

    // Pops expectations whenever the DUT presents a CSR response or a redirect.
    task automatic monitorLoop();
        logic [32:0] er;
        forever begin
            @(negedge clk_i);
            if (csr_en_i === 1'b1) begin
                if (exp_rd.size() == 0) begin
                    checks++; errors++;
                    $display("[TB] FAIL csr_read_unexpected: got 0x%08h, expected no access", csr_rdata_o);
                end else begin
                    er = exp_rd.pop_front();
                    checkOutput($sformatf("csr_rdata[%03h]", csr_addr_i), csr_rdata_o, er[31:0]);
                    checkOutput($sformatf("csr_illegal[%03h]", csr_addr_i), 32'(csr_illegal_o), 32'(er[32]));
                end
            end
            if (redirect_o === 1'b1) begin
                if (exp_pc.size() == 0) begin
                    checks++; errors++;
                    $display("[TB] FAIL redirect_unexpected: got pc 0x%08h, expected no redirect", redirect_pc_o);
                end else begin
                    checkOutput("redirect_pc", redirect_pc_o, exp_pc.pop_front());
                end
            end
        end
    endtask

    function automatic stim_t idleStim();
        stim_t s;
        s.rst = 0; s.exc = 0; s.exc_pc = 0; s.cause = 0; s.tval = 0;
        s.msip = 0; s.mtip = 0; s.meip = 0; s.irq_pc = 0; s.mret = 0; s.instret = 0;
        s.csr_en = 0; s.op = 0; s.addr = 0; s.wdata = 0;
        return s;
    endfunction

    task automatic doCsr(input logic [1:0] op, input logic [11:0] addr, input logic [31:0] wdata);
        stim_t s;
        s = idleStim(); s.csr_en = 1; s.op = op; s.addr = addr; s.wdata = wdata;
        applyStimulus(s);
    endtask

    task automatic doException(input logic [2:0] cause, input logic [31:0] pc, input logic [31:0] tval);
        stim_t s;
        s = idleStim(); s.exc = 1; s.cause = cause; s.exc_pc = pc; s.tval = tval;
        applyStimulus(s);
    endtask

    task automatic doIdle(input int n);
        for (int k = 0; k < n; k++) applyStimulus(idleStim());
    endtask

    task automatic doReset();
        stim_t s;
        s = idleStim(); s.rst = 1;
        applyStimulus(s);
        applyStimulus(s);
    endtask

    initial begin
        stim_t s;
        bit cur_msip = 0, cur_mtip = 0, cur_meip = 0;
        resetModel();
        fork
            monitorLoop();
        join_none

        doReset();
        checkOutput("reset_redirect", 32'(redirect_o), 32'd0);
        checkOutput("reset_redirect_pc", redirect_pc_o, 32'd0);
        doCsr(2'b00, 12'h300, 0);
        doCsr(2'b00, 12'h305, 0);
        doCsr(2'b00, 12'hF14, 0);

        // Exception into a direct-mode vector
        doCsr(2'b01, 12'h305, 32'h100);
        doException(3'd3, 32'h200, 32'h203);
        doIdle(1);
        doCsr(2'b00, 12'h342, 0);
        doCsr(2'b00, 12'h341, 0);
        doCsr(2'b00, 12'h343, 0);
        doCsr(2'b00, 12'h300, 0);

        // Vectored timer interrupt
        doCsr(2'b01, 12'h305, 32'h101);
        doCsr(2'b10, 12'h300, 32'h8);
        doCsr(2'b01, 12'h304, 32'h80);
        s = idleStim(); s.mtip = 1; s.irq_pc = 32'h0000_4446;
        applyStimulus(s);
        doIdle(1);
        doCsr(2'b00, 12'h342, 0);
        doCsr(2'b00, 12'h341, 0);

        // All interrupts pending at once: external wins
        doCsr(2'b01, 12'h304, 32'hFFFF_FFFF);
        doCsr(2'b10, 12'h300, 32'h8);
        s = idleStim(); s.msip = 1; s.mtip = 1; s.meip = 1; s.irq_pc = 32'h0000_5000;
        applyStimulus(s);
        doIdle(1);
        doCsr(2'b00, 12'h342, 0);

        // Exception and CSR write in the same cycle: write dropped
        doCsr(2'b01, 12'h340, 32'hCAFE_0001);
        s = idleStim(); s.exc = 1; s.cause = 3'd5; s.exc_pc = 32'h0000_0700; s.tval = 32'h77;
        s.csr_en = 1; s.op = 2'b01; s.addr = 12'h340; s.wdata = 32'hDEAD_BEEF;
        applyStimulus(s);
        doIdle(1);
        doCsr(2'b00, 12'h340, 0);

        // mret back to mepc
        doCsr(2'b01, 12'h341, 32'h300);
        doCsr(2'b01, 12'h300, 32'h80);
        s = idleStim(); s.mret = 1;
        applyStimulus(s);
        doIdle(1);
        doCsr(2'b00, 12'h300, 0);

        // Read-only write, counter wrap, write-field rules
        doCsr(2'b01, 12'hF14, 32'h1234);
        doCsr(2'b00, 12'hF14, 0);
        doCsr(2'b01, 12'hB80, 32'hFFFF_FFFF);
        doCsr(2'b01, 12'hB00, 32'hFFFF_FFFF);
        doCsr(2'b00, 12'hB80, 0);
        doCsr(2'b00, 12'hB00, 0);
        doCsr(2'b00, 12'hB80, 0);
        doCsr(2'b01, 12'h305, 32'h0000_0402);
        doCsr(2'b00, 12'h305, 0);
        doCsr(2'b01, 12'h341, 32'h0000_0123);
        doCsr(2'b00, 12'h341, 0);
        doCsr(2'b10, 12'h340, 32'h0);
        doCsr(2'b11, 12'h340, 32'h0);
        doCsr(2'b00, 12'h340, 0);
        doCsr(2'b01, 12'h7C0, 32'h55);

        // Reset while redirecting
        doException(3'd1, 32'h0000_0904, 32'h1);
        s = idleStim(); s.rst = 1; s.mret = 1; s.exc = 1;
        applyStimulus(s);
        doIdle(1);
        doCsr(2'b00, 12'h305, 0);
        doCsr(2'b00, 12'h341, 0);

        // Random traffic
        for (int i = 0; i < 1500; i++) begin
            s = idleStim();
            if ($urandom_range(0, 15) == 0) cur_msip = ~cur_msip;
            if ($urandom_range(0, 15) == 0) cur_mtip = ~cur_mtip;
            if ($urandom_range(0, 15) == 0) cur_meip = ~cur_meip;
            s.msip = cur_msip; s.mtip = cur_mtip; s.meip = cur_meip;
            s.rst     = ($urandom_range(0, 199) == 0);
            s.exc     = ($urandom_range(0, 11) == 0);
            s.exc_pc  = $urandom;
            s.cause   = 3'($urandom_range(0, 7));
            s.tval    = $urandom;
            s.irq_pc  = $urandom;
            s.mret    = ($urandom_range(0, 11) == 0);
            s.instret = ($urandom_range(0, 1) == 1);
            s.csr_en  = ($urandom_range(0, 1) == 1);
            s.op      = 2'($urandom_range(0, 3));
            s.addr    = addr_pool[$urandom_range(0, 16)];
            s.wdata   = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            applyStimulus(s);
        end

        doIdle(3);
        checkOutput("redirect_queue_drained", 32'(exp_pc.size()), 32'd0);
        checkOutput("read_queue_drained", 32'(exp_rd.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
